// File: rtl/note_sequencer.sv
// note_sequencer
//
// Queues 32-bit tone commands written by the CPU and plays them back-to-back
// as a square wave on the buzzer pin. Each command word carries a half-period
// in clk cycles (0 = rest) and a duration in ticks of MS_DIV clk cycles
// (0 = discard).
//
// Ports:
//   clk      system clock, all logic on posedge
//   res      synchronous active-high reset (priority over flush)
//   wr_stb   one-cycle pulse, wr_data holds a new command
//   wr_data  [15:0] half_period, [31:16] duration
//   flush    synchronous abort: empty FIFO, stop current note, clear overflow
//   buzz     square-wave output
//   busy     a note or rest is playing (FSM in PLAY)
//   empty    FIFO empty
//   full     FIFO holds DEPTH entries
//   level    FIFO occupancy
//   overflow sticky: a write was dropped because the FIFO was full
//
// Handshake: wr_stb has no back-pressure. A strobe is accepted when the FIFO
// is not full, or when it is full but the sequencer pops the head in the same
// cycle; otherwise the word is dropped and overflow is set.
module note_sequencer #(
    parameter int DEPTH  = 4,
    parameter int MS_DIV = 100000
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       wr_stb,
    input  logic [31:0]                wr_data,
    input  logic                       flush,
    output logic                       buzz,
    output logic                       busy,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(MS_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(MS_DIV - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          overflow_q;

    logic [15:0]   hp_q, hp_d;
    logic [15:0]   dur_cnt_q, dur_cnt_d;
    logic [15:0]   tone_cnt_q, tone_cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          buzz_q, buzz_d;

    logic          pop;
    logic          push;
    logic [31:0]   head;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LEVEL_FULL);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign buzz     = buzz_q;
    assign busy     = (state_q == PLAY);
    assign head     = mem[rd_ptr_q];

    // The head is consumed in every IDLE cycle with data, whether it becomes
    // a note or is discarded for zero duration.
    assign pop  = (state_q == IDLE) && !empty && !flush;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push = wr_stb && !flush && (!full || pop);

    // FIFO bookkeeping; pointers are PW bits wide so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (res || flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (wr_stb && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and level decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // FSM and counter state register.
    always_ff @(posedge clk) begin
        if (res || flush) begin
            state_q    <= IDLE;
            hp_q       <= '0;
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
            tick_cnt_q <= '0;
            buzz_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            buzz_q     <= buzz_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        dur_cnt_d  = dur_cnt_q;
        tone_cnt_d = tone_cnt_q;
        tick_cnt_d = tick_cnt_q;
        buzz_d     = buzz_q;

        case (state_q)
            IDLE: begin
                buzz_d = 1'b0;
                if (pop && (head[31:16] != 16'd0)) begin
                    hp_d       = head[15:0];
                    dur_cnt_d  = head[31:16];
                    tone_cnt_d = '0;
                    tick_cnt_d = '0;
                    state_d    = PLAY;
                end
            end

            PLAY: begin
                // Duration: dur_cnt ticks of MS_DIV cycles each.
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    if (dur_cnt_q == 16'd1) begin
                        dur_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        dur_cnt_d = dur_cnt_q - 16'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end

                // Tone: toggle every hp cycles, silent when hp is zero.
                if (hp_q == 16'd0) begin
                    tone_cnt_d = '0;
                    buzz_d     = 1'b0;
                end else if (tone_cnt_q == (hp_q - 16'd1)) begin
                    tone_cnt_d = '0;
                    buzz_d     = !buzz_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + 16'd1;
                end

                // Leaving PLAY always parks the pin low.
                if (state_d == IDLE) begin
                    tone_cnt_d = '0;
                    buzz_d     = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
